// File: rtl/rtlola_cycle_monitor.sv
// rtlola_cycle_monitor: three-stream runtime monitor core.
// Input events and periodic deadlines are queued, then evaluated one entry
// per cycle. The non-offset dependency cycle output_0/output_2 -> output_1
// is broken by reading output_1's held value for the event-based streams.
module rtlola_cycle_monitor #(
  parameter int unsigned PERIOD_CYCLES = 500,
  parameter int unsigned QUEUE_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [63:0] input_0,
  input  logic signed [63:0] input_1,
  input  logic               new_input_0,
  input  logic               new_input_1,
  output logic signed [63:0] output_0,
  output logic signed [63:0] output_1,
  output logic signed [63:0] output_2,
  output logic               output_0_aktv,
  output logic               output_1_aktv,
  output logic               output_2_aktv,
  output logic               q_push,
  output logic               q_push_valid,
  output logic               q_pop,
  output logic               q_pop_valid,
  output logic               enable_in0,
  output logic               enable_in1,
  output logic               enable_out0,
  output logic               enable_out1,
  output logic               enable_out2
);

  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned NW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [NW-1:0] N_FULL   = NW'(QUEUE_DEPTH);

  logic [CW-1:0] cnt;
  logic          deadline;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;

  logic [63:0] mem_in0 [QUEUE_DEPTH];
  logic [63:0] mem_in1 [QUEUE_DEPTH];
  logic [2:0]  mem_flg [QUEUE_DEPTH];

  logic [63:0] ev_in0, ev_in1;
  logic        ev_n0, ev_n1, ev_dl;
  logic [63:0] nxt0, nxt1, nxt2;

  assign enable_in0  = ev_n0;
  assign enable_out0 = ev_n0;
  assign enable_in1  = ev_n1;
  assign enable_out2 = ev_n1;
  assign enable_out1 = ev_dl;

  // Deadline detection and queue handshake; a pop frees a slot for a same-cycle push.
  always_comb begin
    deadline     = en & ~rst & (cnt == CNT_LAST);
    q_push       = en & ~rst & (new_input_0 | new_input_1 | deadline);
    q_pop        = en & ~rst & (count != '0);
    q_push_valid = q_push & ((count != N_FULL) | q_pop);
  end

  // Period counter: 0..PERIOD_CYCLES-1, frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (q_push_valid)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (q_pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({q_push_valid, q_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (q_push_valid) begin
      mem_in0[wr_ptr] <= input_0;
      mem_in1[wr_ptr] <= input_1;
      mem_flg[wr_ptr] <= {new_input_0, new_input_1, deadline};
    end
  end

  // Pop stage: latch the head entry and its per-stream enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pop_valid <= 1'b0;
      ev_in0      <= '0;
      ev_in1      <= '0;
      ev_n0       <= 1'b0;
      ev_n1       <= 1'b0;
      ev_dl       <= 1'b0;
    end else if (en) begin
      q_pop_valid <= q_pop;
      if (q_pop) begin
        ev_in0 <= mem_in0[rd_ptr];
        ev_in1 <= mem_in1[rd_ptr];
        {ev_n0, ev_n1, ev_dl} <= mem_flg[rd_ptr];
      end else begin
        {ev_n0, ev_n1, ev_dl} <= '0;
      end
    end
  end

  // Stream values: event streams use the held output_1, the periodic stream
  // then sees this entry's fresh output_0/output_2.
  always_comb begin
    nxt0 = enable_out0 ? ev_in0 + output_1 : output_0;
    nxt2 = enable_out2 ? ev_in1 - output_1 : output_2;
    nxt1 = enable_out1 ? nxt0 + nxt2 : output_1;
  end

  // Evaluation stage: outputs double as the hold registers h0/h1/h2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_0      <= '0;
      output_1      <= '0;
      output_2      <= '0;
      output_0_aktv <= 1'b0;
      output_1_aktv <= 1'b0;
      output_2_aktv <= 1'b0;
    end else if (en) begin
      output_0      <= nxt0;
      output_1      <= nxt1;
      output_2      <= nxt2;
      output_0_aktv <= enable_out0;
      output_1_aktv <= enable_out1;
      output_2_aktv <= enable_out2;
    end
  end

endmodule

// File: tb/tb_rtlola_cycle_monitor.sv
// Bench for rtlola_cycle_monitor: directed test-plan steps plus a random
// phase, all compared against a transaction-level queue model.
module tb_rtlola_cycle_monitor;

  localparam int unsigned P = 500;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst, en;
  logic signed [63:0] input_0, input_1;
  logic new_input_0, new_input_1;
  logic signed [63:0] output_0, output_1, output_2;
  logic output_0_aktv, output_1_aktv, output_2_aktv;
  logic q_push, q_push_valid, q_pop, q_pop_valid;
  logic enable_in0, enable_in1, enable_out0, enable_out1, enable_out2;

  rtlola_cycle_monitor #(.PERIOD_CYCLES(P), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en),
    .input_0(input_0), .input_1(input_1),
    .new_input_0(new_input_0), .new_input_1(new_input_1),
    .output_0(output_0), .output_1(output_1), .output_2(output_2),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
    .output_2_aktv(output_2_aktv),
    .q_push(q_push), .q_push_valid(q_push_valid), .q_pop(q_pop),
    .q_pop_valid(q_pop_valid),
    .enable_in0(enable_in0), .enable_in1(enable_in1),
    .enable_out0(enable_out0), .enable_out1(enable_out1), .enable_out2(enable_out2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        n0;
    logic        n1;
    logic        dl;
  } ent_t;

  ent_t        mq[$];
  ent_t        pe;
  logic        pv;
  logic [63:0] m0, m1, m2;
  logic [2:0]  mak;
  int unsigned ecnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dl_now();
    return en && !rst && ((ecnt % P) == P - 1);
  endfunction

  task automatic model_reset();
    mq.delete();
    pv   = 1'b0;
    pe   = '{default: '0};
    m0   = '0;
    m1   = '0;
    m2   = '0;
    mak  = '0;
    ecnt = 0;
  endtask

  // Applied at each rising edge using the inputs that were stable before it.
  task automatic model_edge();
    logic  dl, push, pop;
    int    sz;
    ent_t  e;
    if (rst || !en) return;
    dl   = dl_now();
    push = new_input_0 | new_input_1 | dl;
    if (pv) begin
      logic [63:0] h1_old;
      h1_old = m1;
      if (pe.n0) m0 = pe.a + h1_old;
      if (pe.n1) m2 = pe.b - h1_old;
      if (pe.dl) m1 = m0 + m2;
      mak = {pe.n0, pe.dl, pe.n1};
    end else begin
      mak = '0;
    end
    sz  = mq.size();
    pop = (sz > 0);
    if (pop) begin
      pe = mq.pop_front();
      pv = 1'b1;
    end else begin
      pv = 1'b0;
      pe = '{default: '0};
    end
    if (push && (sz < D || pop)) begin
      e = '{a: input_0, b: input_1, n0: new_input_0, n1: new_input_1, dl: dl};
      mq.push_back(e);
    end
    ecnt++;
  endtask

  // Called at posedge+1: compare at the falling edge, then advance one edge.
  task automatic cycle();
    logic ep, epp, epop;
    #4;
    epop = en && !rst && (mq.size() > 0);
    ep   = en && !rst && (new_input_0 | new_input_1 | dl_now());
    epp  = ep && (mq.size() < D || epop);
    chk("q_push", q_push, ep);
    chk("q_push_valid", q_push_valid, epp);
    chk("q_pop", q_pop, epop);
    chk("q_pop_valid", q_pop_valid, pv);
    chk("enables", {enable_in0, enable_out0, enable_in1, enable_out2, enable_out1},
        {pe.n0, pe.n0, pe.n1, pe.n1, pe.dl});
    chk("output_0", output_0, m0);
    chk("output_1", output_1, m1);
    chk("output_2", output_2, m2);
    chk("aktv", {output_0_aktv, output_1_aktv, output_2_aktv}, mak);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ev(input logic [63:0] a, input logic [63:0] b, input logic s0, input logic s1);
    input_0 = a; input_1 = b; new_input_0 = s0; new_input_1 = s1;
    cycle();
    new_input_0 = 1'b0; new_input_1 = 1'b0;
    input_0 = {$urandom, $urandom}; input_1 = {$urandom, $urandom};
    cycle();
    cycle();
  endtask

  task automatic run_deadline();
    while ((ecnt % P) != P - 1) cycle();
    cycle();
    cycle();
    cycle();
  endtask

  task automatic chk_aktv(input string tag, input logic [2:0] exp);
    chk(tag, {output_0_aktv, output_1_aktv, output_2_aktv}, exp);
  endtask

  logic [63:0] s0, s1, s2;

  initial begin
    rst = 1'b1; en = 1'b1;
    input_0 = '0; input_1 = '0; new_input_0 = 1'b0; new_input_1 = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) cycle();
    chk("rst_outs", {output_0, output_1, output_2}, '0);
    chk_aktv("rst_aktv", 3'b000);
    rst = 1'b0;

    // No push until the first deadline, which arrives PERIOD_CYCLES edges in.
    repeat (P - 1) cycle();
    chk("first_dl_push", q_push, 1'b1);
    cycle(); cycle(); cycle();
    chk("first_dl_o1", output_1, 64'd0);
    chk_aktv("first_dl_aktv", 3'b010);

    ev(64'd1, 64'd1, 1'b1, 1'b1);
    chk("ev11_o0", output_0, 64'd1);
    chk("ev11_o2", output_2, 64'd1);
    chk_aktv("ev11_aktv", 3'b101);
    run_deadline();
    chk("dl2_o1", output_1, 64'd2);
    chk_aktv("dl2_aktv", 3'b010);

    ev(64'd2, 64'd2, 1'b1, 1'b1);
    chk("ev22_o0", output_0, 64'd4);
    chk("ev22_o2", output_2, 64'd0);
    run_deadline();
    chk("dl4_o1", output_1, 64'd4);

    input_0 = 64'd2; new_input_0 = 1'b1;
    cycle();
    new_input_0 = 1'b0;
    cycle();
    chk("in0only_en_in1", enable_in1, 1'b0);
    chk("in0only_en_out2", enable_out2, 1'b0);
    cycle();
    chk_aktv("in0only_aktv", 3'b100);
    chk("in0only_o0", output_0, 64'd6);
    chk("in0only_o2_hold", output_2, 64'd0);

    while ((ecnt % P) != P - 1) cycle();
    ev(64'd3, 64'd3, 1'b1, 1'b1);
    chk("coin_o0", output_0, 64'd7);
    chk("coin_o2", output_2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("coin_o1", output_1, 64'd6);
    chk_aktv("coin_aktv", 3'b111);

    // Make h1 = 1: h0 + h2 after an event equals in0 + in1.
    ev(64'd1, 64'd0, 1'b1, 1'b1);
    run_deadline();
    chk("h1_one", output_1, 64'd1);
    ev(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    chk("wrap_o0", output_0, 64'h8000_0000_0000_0000);
    chk_aktv("wrap_aktv", 3'b100);

    // Strobe while disabled: must not be queued, nothing may move.
    input_0 = 64'd5; new_input_0 = 1'b1;
    cycle();
    en = 1'b0;
    s0 = output_0; s1 = output_1; s2 = output_2;
    repeat (10) cycle();
    chk("en0_hold", {output_0 ^ s0, output_1 ^ s1, output_2 ^ s2}, '0);
    en = 1'b1; new_input_0 = 1'b0;
    cycle(); cycle(); cycle();
    run_deadline();
    chk_aktv("resume_dl_aktv", 3'b010);

    // Random phase.
    repeat (1500) begin
      input_0     = {$urandom, $urandom};
      input_1     = {$urandom, $urandom};
      new_input_0 = ($urandom_range(0, 2) == 0);
      new_input_1 = ($urandom_range(0, 2) == 0);
      en          = ($urandom_range(0, 9) != 0);
      cycle();
    end
    en = 1'b1; new_input_0 = 1'b0; new_input_1 = 1'b0;
    repeat (4) cycle();

    // Asynchronous reset with an entry in flight.
    new_input_0 = 1'b1; new_input_1 = 1'b1;
    cycle();
    rst = 1'b1;
    #2;
    chk("async_rst_outs", {output_0, output_1, output_2}, '0);
    chk("async_rst_qpv", q_pop_valid, 1'b0);
    model_reset();
    #2;
    @(posedge clk); #1;
    new_input_0 = 1'b0; new_input_1 = 1'b0;
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk_aktv("post_rst_aktv", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
